// File: rtl/uart_pkg.sv
// Shared types and helpers for the queued UART transmitter.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE,
      PAR_EVEN,
      PAR_ODD
   } parity_t;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP
   } tx_state_t;

   localparam int MAX_DATA_BITS = 9;

   // Frames narrower than MAX_DATA_BITS arrive zero-extended, so the
   // extra zeros do not disturb the XOR.
   function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                        input parity_t mode);
      case (mode)
         PAR_EVEN: return ^data;
         PAR_ODD:  return ~^data;
         default:  return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/uart_tx_q_sync_fifo.sv
// Synchronous show-ahead FIFO: dout always presents the head entry while not empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr,
   input  logic [WIDTH-1:0]         din,
   input  logic                     rd,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wp_q, rp_q;
   logic [CW-1:0]    count_q, count_d;
   logic             full_q;
   logic             push, pop;

   // A write while full is dropped even if a read frees a slot in the same cycle.
   assign push    = wr & ~full_q;
   assign pop     = rd & (count_q != '0);
   assign count_d = count_q + CW'(push) - CW'(pop);

   // NOTE: storage carries no reset; only pointers and occupancy define validity,
   // so clearing the array would add reset fan-out for no functional gain.
   always_ff @(posedge clk) begin
      if (push) mem_q[wp_q] <= din;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
      end else begin
         if (push) wp_q <= wp_q + 1'b1;
         if (pop)  rp_q <= rp_q + 1'b1;
         count_q <= count_d;
         full_q  <= (count_d == CW'(DEPTH));
      end
   end

   assign dout  = mem_q[rp_q];
   assign full  = full_q;
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/uart_tx_q.sv
// UART transmitter fed by a DEPTH-entry queue; frames go out back-to-back
// with configurable data width, parity and stop bits.
module uart_tx_q
   import uart_pkg::*;
#(
   parameter int BAUD_DIV  = 2604,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1,
   parameter int DEPTH     = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr,
   input  logic [DATA_BITS-1:0]   tx_data,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count,
   output logic                   ovf,
   output logic                   tx,
   output logic                   busy,
   output logic                   tx_done
);

   localparam int             BW        = $clog2(BAUD_DIV);
   localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam parity_t        PMODE     = (PARITY == 1) ? PAR_EVEN :
                                          (PARITY == 2) ? PAR_ODD  : PAR_NONE;

   if (BAUD_DIV < 2) begin : g_bad_baud
      $error("uart_tx_q: BAUD_DIV must be >= 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_width
      $error("uart_tx_q: DATA_BITS must be 5..9");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_q: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_q: STOP_BITS must be 1 or 2");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_q: DEPTH must be a power of 2, >= 2");
   end

   tx_state_t             state_q, state_d;
   logic [BW-1:0]         baud_q, baud_d;
   logic [3:0]            bit_q, bit_d;
   logic [DATA_BITS-1:0]  shift_q, shift_d;
   logic                  par_q, par_d;
   logic                  tx_q, tx_d;
   logic                  last_q, done_q, ovf_q;
   logic                  bit_end, load, stop_end;
   logic [DATA_BITS-1:0]  fifo_dout;
   logic                  fifo_empty, fifo_full;

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .wr    (wr),
      .din   (tx_data),
      .rd    (load),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (count)
   );

   assign bit_end = (baud_q == BAUD_LAST);

   // tx_d is the line level for the current state; registering it delays the
   // whole line (and tx_done) by one cycle relative to the state machine.
   // NOTE: every always_comb output is defaulted first so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      baud_d   = (state_q == IDLE || bit_end) ? '0 : baud_q + 1'b1;
      bit_d    = bit_q;
      shift_d  = shift_q;
      par_d    = par_q;
      tx_d     = 1'b1;
      load     = 1'b0;
      stop_end = 1'b0;

      case (state_q)
         IDLE: load = ~fifo_empty;
         START: begin
            tx_d = 1'b0;
            if (bit_end) begin
               state_d = DATA;
               bit_d   = '0;
            end
         end
         DATA: begin
            tx_d = shift_q[0];
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_q == 4'(DATA_BITS - 1)) begin
                  bit_d   = '0;
                  state_d = (PMODE != PAR_NONE) ? PAR : STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         PAR: begin
            tx_d = par_q;
            if (bit_end) begin
               state_d = STOP;
               bit_d   = '0;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (bit_q == 4'(STOP_BITS - 1)) begin
                  stop_end = 1'b1;
                  state_d  = IDLE;
                  load     = ~fifo_empty;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         shift_d = fifo_dout;
         par_d   = calc_parity(MAX_DATA_BITS'(fifo_dout), PMODE);
         baud_d  = '0;
         bit_d   = '0;
         state_d = START;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         last_q  <= stop_end;
         done_q  <= last_q;
         ovf_q   <= wr & fifo_full;
      end
   end

   assign tx      = tx_q;
   assign tx_done = done_q;
   assign ovf     = ovf_q;
   assign full    = fifo_full;
   assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_q.sv
// Self-checking bench for uart_tx_q: four configurations, scoreboarded frames
// checked cycle by cycle on the serial line.
module tb_uart_tx_q;

   localparam int BD = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   int         cyc = 0;

   logic       wr     [4];
   logic [7:0] din    [4];
   logic       tx_w   [4];
   logic       busy_w [4];
   logic       done_w [4];
   logic       full_w [4];
   logic       ovf_w  [4];
   logic [2:0] cnt_w  [4];

   int cfg_db  [4] = '{8, 8, 8, 7};
   int cfg_par [4] = '{0, 1, 2, 0};
   int cfg_sb  [4] = '{1, 2, 1, 1};

   typedef struct {
      logic [15:0] bits;
      int          len;
   } frame_t;

   frame_t exp_q[$];
   int     errors = 0;
   int     checks = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_q #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DEPTH(4)) u_8n1 (
      .clk(clk), .rst_n(rst_n), .wr(wr[0]), .tx_data(din[0]), .full(full_w[0]),
      .count(cnt_w[0]), .ovf(ovf_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0]));

   uart_tx_q #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .DEPTH(4)) u_8e2 (
      .clk(clk), .rst_n(rst_n), .wr(wr[1]), .tx_data(din[1]), .full(full_w[1]),
      .count(cnt_w[1]), .ovf(ovf_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1]));

   uart_tx_q #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DEPTH(4)) u_8o1 (
      .clk(clk), .rst_n(rst_n), .wr(wr[2]), .tx_data(din[2]), .full(full_w[2]),
      .count(cnt_w[2]), .ovf(ovf_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .tx_done(done_w[2]));

   uart_tx_q #(.BAUD_DIV(BD), .DATA_BITS(7), .PARITY(0), .STOP_BITS(1), .DEPTH(4)) u_7n1 (
      .clk(clk), .rst_n(rst_n), .wr(wr[3]), .tx_data(din[3][6:0]), .full(full_w[3]),
      .count(cnt_w[3]), .ovf(ovf_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .tx_done(done_w[3]));

   // Reference frame: start 0, data LSB first, optional parity, stop 1s.
   function automatic frame_t make_frame(input int idx, input logic [7:0] d);
      frame_t f;
      int     n;
      logic   p;
      f.bits = '1;
      n      = 0;
      p      = 1'b0;
      f.bits[n] = 1'b0;
      n++;
      for (int i = 0; i < cfg_db[idx]; i++) begin
         f.bits[n] = d[i];
         p = p ^ d[i];
         n++;
      end
      if (cfg_par[idx] != 0) begin
         f.bits[n] = (cfg_par[idx] == 2) ? ~p : p;
         n++;
      end
      f.len = n + cfg_sb[idx];
      return f;
   endfunction

   task automatic push_byte(input int idx, input logic [7:0] d, input bit accepted);
      wr[idx]  = 1'b1;
      din[idx] = d;
      if (accepted) exp_q.push_back(make_frame(idx, d));
   endtask

   task automatic run_frames(input int idx, input int n, input bit gapless, input string name);
      frame_t f;
      int     w, bad, extra, bad_b;
      logic   bad_v, bad_e;
      for (int k = 0; k < n; k++) begin
         w = 0;
         while (tx_w[idx] !== 1'b0 && w < 400) begin
            @(negedge clk);
            w++;
         end
         checks++;
         if (tx_w[idx] !== 1'b0) begin
            errors++;
            $display("FAIL %s start_timeout frame %0d: tx=%b required 0", name, k, tx_w[idx]);
            return;
         end
         if (gapless && k > 0) begin
            checks++;
            if (w != 0) begin
               errors++;
               $display("FAIL %s gap frame %0d: idle cycles=%0d required 0", name, k, w);
            end
         end
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected_frame %0d: scoreboard empty", name, k);
            return;
         end
         f     = exp_q.pop_front();
         bad   = 0;
         extra = 0;
         bad_b = 0;
         bad_v = 1'b0;
         bad_e = 1'b0;
         for (int b = 0; b < f.len; b++) begin
            for (int c = 0; c < BD; c++) begin
               if (tx_w[idx] !== f.bits[b]) begin
                  if (bad == 0) begin
                     bad_b = b;
                     bad_v = tx_w[idx];
                     bad_e = f.bits[b];
                  end
                  bad++;
               end
               if ((b != 0 || c != 0) && done_w[idx] !== 1'b0) extra++;
               @(negedge clk);
            end
         end
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL %s frame %0d bits: %0d wrong cycles, first at bit %0d got %b required %b",
                     name, k, bad, bad_b, bad_v, bad_e);
         end
         checks++;
         if (done_w[idx] !== 1'b1) begin
            errors++;
            $display("FAIL %s frame %0d tx_done: got %b required 1", name, k, done_w[idx]);
         end
         checks++;
         if (extra != 0) begin
            errors++;
            $display("FAIL %s frame %0d early_done: %0d cycles got 1 required 0", name, k, extra);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wr[i]  = 1'b0;
         din[i] = '0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (tx_w[i] !== 1'b1 || busy_w[i] !== 1'b0 || done_w[i] !== 1'b0) begin
            errors++;
            $display("FAIL reset line %0d: tx=%b busy=%b done=%b required 1 0 0",
                     i, tx_w[i], busy_w[i], done_w[i]);
         end
         checks++;
         if (ovf_w[i] !== 1'b0 || full_w[i] !== 1'b0 || cnt_w[i] !== 3'd0) begin
            errors++;
            $display("FAIL reset fifo %0d: ovf=%b full=%b count=%0d required 0 0 0",
                     i, ovf_w[i], full_w[i], cnt_w[i]);
         end
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single();
      @(negedge clk);
      push_byte(0, 8'h55, 1'b1);
      @(negedge clk);
      wr[0] = 1'b0;
      checks++;
      if (cnt_w[0] !== 3'd1 || busy_w[0] !== 1'b0 || tx_w[0] !== 1'b1) begin
         errors++;
         $display("FAIL single edge_n: count=%0d busy=%b tx=%b required 1 0 1", cnt_w[0], busy_w[0], tx_w[0]);
      end
      @(negedge clk);
      checks++;
      if (cnt_w[0] !== 3'd0 || busy_w[0] !== 1'b1 || tx_w[0] !== 1'b1) begin
         errors++;
         $display("FAIL single pop: count=%0d busy=%b tx=%b required 0 1 1", cnt_w[0], busy_w[0], tx_w[0]);
      end
      @(negedge clk);
      checks++;
      if (tx_w[0] !== 1'b0) begin
         errors++;
         $display("FAIL single tx_fall: tx=%b required 0", tx_w[0]);
      end
      run_frames(0, 1, 1'b0, "single");
      checks++;
      if (busy_w[0] !== 1'b0) begin
         errors++;
         $display("FAIL single busy_end: got %b required 0", busy_w[0]);
      end
   endtask

   task automatic test_parity();
      for (int idx = 1; idx <= 2; idx++) begin
         @(negedge clk);
         push_byte(idx, 8'hA5, 1'b1);
         @(negedge clk);
         wr[idx] = 1'b0;
         run_frames(idx, 1, 1'b0, (idx == 1) ? "even_2stop" : "odd");
         checks++;
         if (busy_w[idx] !== 1'b0) begin
            errors++;
            $display("FAIL parity busy_end %0d: got %b required 0", idx, busy_w[idx]);
         end
      end
   endtask

   task automatic test_back_to_back();
      fork
         begin
            for (int i = 1; i <= 3; i++) begin
               @(negedge clk);
               push_byte(0, 8'(i), 1'b1);
            end
            @(negedge clk);
            wr[0] = 1'b0;
         end
         run_frames(0, 3, 1'b1, "back_to_back");
      join
      checks++;
      if (cnt_w[0] !== 3'd0 || busy_w[0] !== 1'b0) begin
         errors++;
         $display("FAIL back_to_back drained: count=%0d busy=%b required 0 0", cnt_w[0], busy_w[0]);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] bytes [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      int         noise;
      fork
         begin
            @(negedge clk);
            push_byte(0, bytes[0], 1'b1);
            for (int i = 1; i <= 6; i++) begin
               @(negedge clk);
               if (i == 1 || i == 2) begin
                  checks++;
                  if (cnt_w[0] !== 3'd1) begin
                     errors++;
                     $display("FAIL overflow count_e%0d: got %0d required 1", i, cnt_w[0]);
                  end
               end
               if (i == 4) begin
                  checks++;
                  if (full_w[0] !== 1'b0 || cnt_w[0] !== 3'd3) begin
                     errors++;
                     $display("FAIL overflow pre_full: full=%b count=%0d required 0 3", full_w[0], cnt_w[0]);
                  end
               end
               if (i == 5) begin
                  checks++;
                  if (full_w[0] !== 1'b1 || cnt_w[0] !== 3'd4 || ovf_w[0] !== 1'b0) begin
                     errors++;
                     $display("FAIL overflow full: full=%b count=%0d ovf=%b required 1 4 0",
                              full_w[0], cnt_w[0], ovf_w[0]);
                  end
               end
               if (i == 6) begin
                  checks++;
                  if (ovf_w[0] !== 1'b1 || cnt_w[0] !== 3'd4) begin
                     errors++;
                     $display("FAIL overflow ovf: ovf=%b count=%0d required 1 4", ovf_w[0], cnt_w[0]);
                  end
               end
               if (i < 6) push_byte(0, bytes[i], (i < 5));
               else       wr[0] = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (ovf_w[0] !== 1'b0) begin
               errors++;
               $display("FAIL overflow ovf_pulse: got %b required 0", ovf_w[0]);
            end
         end
         run_frames(0, 5, 1'b1, "overflow");
      join
      noise = 0;
      repeat (3 * BD) begin
         if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || cnt_w[0] !== 3'd0) noise++;
         @(negedge clk);
      end
      checks++;
      if (noise != 0) begin
         errors++;
         $display("FAIL overflow extra_frame: %0d non-idle cycles required 0", noise);
      end
   endtask

   task automatic test_width7();
      @(negedge clk);
      push_byte(3, 8'hFF, 1'b1);
      @(negedge clk);
      wr[3] = 1'b0;
      run_frames(3, 1, 1'b0, "width7");
   endtask

   task automatic test_reset_mid();
      int w, noise;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         push_byte(0, 8'hC3 + 8'(i), 1'b0);
      end
      @(negedge clk);
      wr[0] = 1'b0;
      w = 0;
      while (tx_w[0] !== 1'b0 && w < 100) begin
         @(negedge clk);
         w++;
      end
      repeat (BD + 40) @(negedge clk);
      checks++;
      if (cnt_w[0] !== 3'd2 || busy_w[0] !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid pre: count=%0d busy=%b required 2 1", cnt_w[0], busy_w[0]);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || cnt_w[0] !== 3'd0 || full_w[0] !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid async: tx=%b busy=%b count=%0d full=%b required 1 0 0 0",
                  tx_w[0], busy_w[0], cnt_w[0], full_w[0]);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      noise = 0;
      repeat (20 * BD) begin
         @(negedge clk);
         if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0 || cnt_w[0] !== 3'd0) noise++;
      end
      checks++;
      if (noise != 0) begin
         errors++;
         $display("FAIL reset_mid after: %0d non-idle cycles required 0", noise);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_parity();
      test_back_to_back();
      test_overflow();
      test_width7();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard leftover: %0d frames required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uart_tx_q.md
Name: uart_tx_q

Overview:
Parametrised UART transmitter with an integrated transmit queue. It replaces the fixed 8N1 single-byte transmitter.
- Accepts bytes from the host side through a push strobe into a DEPTH-entry FIFO.
- Serialises frames back-to-back with configurable data width, parity and stop bits.
- Feeds the serial line to the remote receiver.
- Reports frame completion, busy/idle state and overflow.

Parameters:
BAUD_DIV, 2604, clocks per bit; every bit (start, data, parity, stop) lasts exactly BAUD_DIV clk cycles; legal values ≥ 2.
DATA_BITS, 8, data bits per frame, 5..9; sent LSB first.
PARITY, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, 1 or 2.
DEPTH, 4, FIFO entries; power of 2, ≥ 2.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wr  in  1  push strobe; tx_data is sampled on the clk edge where wr=1
tx_data  in  DATA_BITS  byte to queue
full  out  1  FIFO holds DEPTH entries (registered)
count  out  $clog2(DEPTH)+1  FIFO occupancy
ovf  out  1  one-cycle pulse when wr=1 while full=1
tx  out  1  serial line, registered, idle high
busy  out  1  state != IDLE
tx_done  out  1  one-cycle pulse in the cycle after the last stop bit ends

Behaviour:
- Reset (async, rst_n=0):
  - tx=1, busy=0, tx_done=0, ovf=0, full=0, count=0.
  - FIFO pointers cleared; state=IDLE; baud and bit counters cleared.
  - Reset mid-frame aborts the frame immediately and drops queued data.
- FIFO:
  - Push is accepted when wr=1 and full=0. A push while full is dropped and ovf pulses; this holds even if a pop occurs in the same cycle.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- States: IDLE, START, DATA, PAR, STOP.
  - IDLE: if count≠0, pop the head into the shift register, clear the baud counter, go to START. Otherwise stay.
  - START: tx=0 for BAUD_DIV cycles, then go to DATA.
  - DATA: tx=shift[0]. At each bit end, shift right. After DATA_BITS bits, go to PAR if PARITY≠0, else STOP.
  - PAR: tx = parity bit for BAUD_DIV cycles. Even: XOR of data bits. Odd: inverted XOR. Parity is computed at load time.
  - STOP: tx=1 for STOP_BITS×BAUD_DIV cycles. At the end, pulse tx_done. Then:
    - if count≠0: pop and go to START directly, with no idle bit between frames;
    - else go to IDLE.
- Latency: with the block in IDLE and the FIFO empty, wr at edge N gives count=1 after N. The pop occurs at edge N+1, and tx falls at edge N+2.
- Baud counter:
  - Counts 0..BAUD_DIV-1; the bit-end strobe is asserted at BAUD_DIV-1 and the counter wraps to 0.
  - Width is $clog2(BAUD_DIV).
  - Held at 0 in IDLE.
- Frame length in bits: 1 + DATA_BITS + (PARITY≠0) + STOP_BITS.
- tx is driven from a register, so no glitches appear on the line.
- count changes in the same cycle as the pop edge.

Decomposition:
- Package uart_pkg:
  - parity_t enum (PAR_NONE, PAR_EVEN, PAR_ODD);
  - tx_state_t enum (IDLE, START, DATA, PAR, STOP);
  - helper function calc_parity(data, mode).
- Sub-module sync_fifo:
  - parameters WIDTH, DEPTH; ports wr, din, rd, dout, full, empty, count, async reset;
  - show-ahead dout, so the head is valid whenever empty=0.
- uart_tx_q contains the FSM, baud counter, bit counter and shift register.
- Parameter legality is checked with elaboration-time assertions.

Test Plan:
1. BAUD_DIV=16, 8N1, write 0x55 from idle → tx low 2 cycles after wr. Line bits are 0,1,0,1,0,1,0,1,0,1 at 16 clk each. tx_done pulses once, 160 clks after tx fell; busy then drops.
2. PARITY=1 (even), write 0xA5 → parity bit 0; PARITY=2 (odd), write 0xA5 → parity bit 1. STOP_BITS=2 → stop high for 32 clks before tx_done.
3. Write 0x01, 0x02, 0x03 on consecutive cycles → three contiguous frames with no idle gap. tx_done pulses 3 times, count returns to 0.
4. DEPTH=4, six writes on consecutive cycles from idle → first write popped at cycle 1, full asserted after the 5th write. The 6th write is dropped with an ovf pulse. Exactly 5 frames are sent, in order.
5. DATA_BITS=7, PARITY=0, write 0x7F → 9-bit frame: start 0, seven 1s, stop 1; bit 7 of tx_data is ignored.
6. Assert rst_n low mid-DATA with 2 entries queued → tx=1 and busy=0 immediately, count=0. No tx_done pulse, and no further frames after release.
